// File: rtl/clock_measure_pkg.sv
// clock_measure_pkg: shared defaults and FSM state encoding for the clock measurement block.
package clock_measure_pkg;
    localparam int CNT_W_DEF = 16;
    localparam int LOCK_MATCHES_DEF = 2;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;
endpackage

// File: rtl/clock_measure_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus registered rise/fall detector.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] sync;
    logic       level_d;
    logic [3:0] primed;
    // Edges are suppressed until every stage holds a real sample, so a slow clock
    // that is already high at reset release does not look like a fresh rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync    <= '0;
            o_level <= 1'b0;
            level_d <= 1'b0;
            primed  <= '0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            sync    <= {sync[0], i_async};
            o_level <= sync[1];
            level_d <= o_level;
            primed  <= {primed[2:0], 1'b1};
            o_rise  <= primed[3] & o_level & ~level_d;
            o_fall  <= primed[3] & ~o_level & level_d;
        end
    end
endmodule

// File: rtl/clock_measure.sv
// clock_measure: recovers the period, high and low phase lengths of a slow clock
// in fast-clock cycles, with lock and timeout indication.
module clock_measure
    import clock_measure_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LOCK_MATCHES = LOCK_MATCHES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_slow_clk,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic             o_odd,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [MW-1:0] LM = MW'(LOCK_MATCHES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, high, high_n, period_n;
    logic [CNT_W:0]   sum;
    logic [MW-1:0]    match, match_n;
    logic             rise, fall, unused_level, publish, expire;

    sync_edge_det u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_slow_clk),
        .o_level (unused_level),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    assign sum      = {1'b0, high} + {1'b0, cnt};
    assign period_n = sum[CNT_W] ? MAX : sum[CNT_W-1:0];
    assign match_n  = (period_n != o_period) ? '0 : (match == LM ? LM : match + MW'(1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        high_n  = high;
        publish = 1'b0;
        expire  = 1'b0;
        if (!i_en) state_n = IDLE;
        else begin
            case (state)
                IDLE: begin
                    state_n = WAIT_RISE;
                    cnt_n   = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_n   = ONE;
                        state_n = MEAS_HIGH;
                    end else if (cnt == MAX) expire = 1'b1;
                    else cnt_n = cnt + ONE;
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_n  = cnt;
                        cnt_n   = ONE;
                        state_n = MEAS_LOW;
                    end else if (cnt == MAX) begin
                        expire  = 1'b1;
                        state_n = WAIT_RISE;
                    end else cnt_n = cnt + ONE;
                end
                MEAS_LOW: begin
                    if (rise) begin
                        publish = 1'b1;
                        cnt_n   = ONE;
                        state_n = MEAS_HIGH;
                    end else if (cnt == MAX) begin
                        expire  = 1'b1;
                        state_n = WAIT_RISE;
                    end else cnt_n = cnt + ONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            high       <= '0;
            match      <= '0;
            o_period   <= '0;
            o_high_cnt <= '0;
            o_low_cnt  <= '0;
            o_odd      <= 1'b0;
            o_valid    <= 1'b0;
            o_locked   <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            high      <= high_n;
            o_valid   <= publish;
            o_timeout <= !publish && (expire || o_timeout);
            if (publish) begin
                o_period   <= period_n;
                o_high_cnt <= high;
                o_low_cnt  <= cnt;
                o_odd      <= period_n[0];
                match      <= match_n;
                o_locked   <= (match_n == LM);
            end else if (expire || !i_en) begin
                match    <= '0;
                o_locked <= 1'b0;
            end
        end
    end
endmodule
